// File: rtl/channel_req_arbiter.sv
// channel_req_arbiter: locked one-hot channel grant with per-class round-robin; optional LP anti-starvation via LP_AGING_EN
module channel_req_arbiter #(
    parameter int NUM_PORTS = 5,
    parameter int PTR_W     = 3,
    parameter int AGE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_PORTS-1:0]     hp_req_i,
    input  logic [NUM_PORTS-1:0]     lp_req_i,
    input  logic [NUM_PORTS-1:0]     release_i,
    input  logic                     channel_ready_i,
    output logic [2*NUM_PORTS-1:0]   arb_req_o,
    output logic                     HP_output_req_o,
    output logic                     LP_output_req_o,
    output logic [2*NUM_PORTS-1:0]   channel_req_o,
    output logic                     busy_o
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t                 state_q;
    logic [PTR_W-1:0]       hp_ptr_q, lp_ptr_q, owner_q, hp_idx, lp_idx, sel_idx, owner_inc;
    logic                   owner_hp_q, any_hp, any_lp, pick_lp, start, grant_end;
    logic [NUM_PORTS-1:0]   sel_oh;
    logic [2*NUM_PORTS-1:0] arb_req_q, channel_req_q;
    logic                   hp_out_q, lp_out_q, busy_q;

    assign any_hp    = |hp_req_i;
    assign any_lp    = |lp_req_i;
    assign start     = (state_q == IDLE) && channel_ready_i && (any_hp || any_lp);
    assign sel_idx   = pick_lp ? lp_idx : hp_idx;
    assign sel_oh    = NUM_PORTS'(1) << sel_idx;
    assign grant_end = release_i[owner_q] | ~(owner_hp_q ? hp_req_i[owner_q] : lp_req_i[owner_q]);
    assign owner_inc = (owner_q == PTR_W'(NUM_PORTS-1)) ? '0 : owner_q + 1'b1;

    // rotating-priority search; offsets walked downward so the smallest offset from the pointer wins
    always_comb begin
        hp_idx = '0;
        lp_idx = '0;
        for (int k = NUM_PORTS-1; k >= 0; k--) begin
            if (hp_req_i[(int'(hp_ptr_q)+k) % NUM_PORTS]) hp_idx = PTR_W'((int'(hp_ptr_q)+k) % NUM_PORTS);
            if (lp_req_i[(int'(lp_ptr_q)+k) % NUM_PORTS]) lp_idx = PTR_W'((int'(lp_ptr_q)+k) % NUM_PORTS);
        end
    end

`ifdef LP_AGING_EN
    localparam int AGE_W = $clog2(AGE_LIMIT+1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);
    logic [AGE_W-1:0] age_q;

    assign pick_lp = ~any_hp | ((age_q == AGE_MAX) & any_lp);

    // count consecutive HP grants that bypassed a pending LP request
    always_ff @(posedge clk) begin
        if (rst)
            age_q <= '0;
        else if (start)
            age_q <= (pick_lp || !any_lp) ? '0 : (age_q == AGE_MAX) ? age_q : age_q + 1'b1;
    end
`else
    assign pick_lp = ~any_hp;
`endif

    // request snapshot plus IDLE/LOCKED grant FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            hp_ptr_q      <= '0;
            lp_ptr_q      <= '0;
            owner_q       <= '0;
            owner_hp_q    <= 1'b0;
            arb_req_q     <= '0;
            hp_out_q      <= 1'b0;
            lp_out_q      <= 1'b0;
            channel_req_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            arb_req_q <= {hp_req_i, lp_req_i};
            hp_out_q  <= any_hp;
            lp_out_q  <= any_lp;
            case (state_q)
                IDLE: if (start) begin
                    state_q       <= LOCKED;
                    owner_q       <= sel_idx;
                    owner_hp_q    <= ~pick_lp;
                    channel_req_q <= pick_lp ? {NUM_PORTS'(0), sel_oh} : {sel_oh, NUM_PORTS'(0)};
                    busy_q        <= 1'b1;
                end
                LOCKED: if (grant_end) begin
                    state_q       <= IDLE;
                    channel_req_q <= '0;
                    busy_q        <= 1'b0;
                    if (owner_hp_q) hp_ptr_q <= owner_inc;
                    else            lp_ptr_q <= owner_inc;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assert property (@(posedge clk) $onehot0(channel_req_q));

    assign arb_req_o       = arb_req_q;
    assign HP_output_req_o = hp_out_q;
    assign LP_output_req_o = lp_out_q;
    assign channel_req_o   = channel_req_q;
    assign busy_o          = busy_q;
endmodule

// File: doc/channel_req_arbiter.md
Name: channel_req_arbiter

Overview:
Per-output-port arbiter that sits directly upstream of the bidirectional channel controller.
- Collects HP/LP flit-transfer requests from NUM_PORTS input ports.
- Raises HP/LP output requests so the controller can turn the shared bidirectional channel toward output.
- Issues a one-hot, locked grant (channel_req) that holds until the owning port's packet tail has passed.
- Round-robin fairness is kept separately within each priority class.

Parameters:
NUM_PORTS, 5, number of requesting input ports (N)
PTR_W, 3, width of round-robin pointers; must satisfy 2**PTR_W >= NUM_PORTS
AGE_LIMIT, 8, consecutive HP grants tolerated while LP is pending (used only with LP_AGING_EN)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
hp_req  input  N  per-port high-priority request, level, held until granted and released
lp_req  input  N  per-port low-priority request, level
release  input  N  per-port tail-flit pulse: owner's packet finished this cycle
channel_ready  input  1  from channel controller: channel currently driven in output direction
arb_req  output  2N  registered request snapshot, {hp_req, lp_req}
HP_output_req  output  1  registered OR of hp_req
LP_output_req  output  1  registered OR of lp_req
channel_req  output  2N  one-hot grant, {HP grants[N-1:0], LP grants[N-1:0]}, or all zero
busy  output  1  high while a grant is locked

Behaviour:
- Reset (rst=1 at a clock edge):
  - All outputs become 0.
  - hp_ptr and lp_ptr become 0.
  - FSM goes to IDLE.
  - Age counter becomes 0.
  - Reset mid-grant drops channel_req on the next edge. No release is required.
- Every cycle:
  - arb_req <= {hp_req, lp_req}.
  - HP_output_req <= |hp_req.
  - LP_output_req <= |lp_req.
  - These update independently of FSM state, with a 1-cycle latency.
- FSM states: IDLE and LOCKED.
- IDLE:
  - channel_req = 0 and busy = 0.
  - Transitions only when channel_ready = 1 and (|hp_req | |lp_req).
  - Winner selection:
    - If any hp_req is set, choose the first set HP bit searching upward from hp_ptr, wrapping modulo N.
    - Otherwise choose the first set LP bit searching upward from lp_ptr, wrapping.
  - Next edge: channel_req sets exactly one bit, busy = 1, FSM goes to LOCKED. Grant latency is 1 cycle after qualifying request plus ready.
  - If channel_ready = 0, stay in IDLE. Requests remain visible on HP_output_req/LP_output_req.
- LOCKED:
  - channel_req is held constant, regardless of channel_ready or other requests. There is no preemption, including HP over a locked LP grant.
  - End of grant: release[owner] = 1, or the owner's request of the granted class deasserts (abort).
  - On the next edge after grant end:
    - channel_req = 0, busy = 0, FSM returns to IDLE.
    - The pointer of the granted class becomes (owner+1) mod N. The other pointer is unchanged.
  - One mandatory idle (bubble) cycle separates consecutive grants.
  - release on a non-owner port is ignored in every state.
- Simultaneous release[owner] and a new request from the owner: the grant still ends. The owner re-arbitrates in IDLE at its new, lowest round-robin priority.
- Pointer wrap: owner N-1 sets the pointer to 0.
- Invariant: channel_req is always one-hot or zero. Two bits set is an assertion failure.

Optional Feature:
Macro LP_AGING_EN.
- Defined:
  - A counter of consecutive HP grants issued while |lp_req was 1 at the grant decision.
  - When the counter reaches AGE_LIMIT, the next IDLE decision selects LP (round-robin from lp_ptr) even if HP is pending.
  - The counter clears on any LP grant, or on an HP grant decided with no LP pending.
  - Counter saturates at AGE_LIMIT. Reset value is 0.
- Not defined:
  - Strict HP-over-LP priority. LP may starve indefinitely.
  - No counter logic is synthesised.

Test Plan:
1. rst=1 for 2 cycles with hp_req=5'b11111 -> all outputs 0 during reset; after release of rst with channel_ready=1, the first grant is channel_req=10'b00001_00000 (HP port 0).
2. hp_req=5'b10100, channel_ready=1, pulse release on owner each grant -> HP grants in order port2, port4, port2, each lasting until release+1 cycle, with one zero cycle between grants.
3. lp_req=5'b00011 and hp_req=0, grant LP port0; raise hp_req[3] while LOCKED -> LP grant held until release[0]; next grant is 10'b01000_00000.
4. channel_ready=0 with lp_req=5'b00100 -> channel_req stays 0 and LP_output_req=1 one cycle later; raise channel_ready -> 10'b00000_00100 one cycle later.
5. Grant HP port1, then deassert hp_req[1] without release; also pulse release[3] while LOCKED -> release[3] ignored; grant ends on the deassert; hp_ptr=2.
6. LP_AGING_EN defined, AGE_LIMIT=2, hp_req=5'b00001 and lp_req=5'b00010 held constant -> grant sequence HP0, HP0, LP1, HP0, HP0, LP1; without the macro -> HP0 repeats forever.
